// File: rtl/alu_result_checker.sv
// alu_result_checker: golden-model response checker for the 4-bit registered ALU.
// Latency: vector applied -> compare after LATENCY clocks; counters/mismatch/ff_* one cycle later.
// Backpressure: none; every in_valid cycle in RUN is accepted, in_valid is ignored elsewhere.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   start, vec_total       begin a run of vec_total vectors (accepted in IDLE/DONE only)
//   in_valid, select, a, b, c_in   vector being applied to the ALU this cycle
//   dut_out, dut_cout      registered ALU result to be checked
//   busy, done, mismatch   run status and one-cycle failure pulse
//   pass_count, fail_count saturating compare counters
//   ff_valid, ff_sel, ff_exp, ff_got   first-failure record
module alu_result_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] vec_total,
    input  logic             in_valid,
    input  logic [2:0]       select,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             c_in,
    input  logic [3:0]       dut_out,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             ff_valid,
    output logic [2:0]       ff_sel,
    output logic [4:0]       ff_exp,
    output logic [4:0]       ff_got
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Golden ALU result as {carry, out}.
    function automatic logic [4:0] golden(
        input logic [2:0] sel,
        input logic [3:0] op_a,
        input logic [3:0] op_b,
        input logic       cin
    );
        logic [4:0] res;
        res = 5'h00;
        case (sel)
            3'b000: res = {1'b0, ~op_a};
            3'b001: res = {1'b0, op_a} + {1'b0, op_b} + {4'b0000, cin};
            3'b010: res = {1'b0, op_a & op_b};
            3'b011: res = {1'b0, op_a | op_b};
            3'b100: res = {1'b0, op_a ^ op_b};
            3'b101: res = {op_a[3], op_a[2:0], cin};   // rotate left through carry
            3'b110: res = 5'h00;
            3'b111: res = 5'h0F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        accepted_q, accepted_d;
    logic [CNT_W-1:0]        vec_total_q, vec_total_d;

    logic [LATENCY-1:0]      pipe_vld_q, pipe_vld_d;
    logic [LATENCY-1:0][4:0] pipe_exp_q, pipe_exp_d;
    logic [LATENCY-1:0][2:0] pipe_sel_q, pipe_sel_d;

    logic [CNT_W-1:0]        pass_q, pass_d;
    logic [CNT_W-1:0]        fail_q, fail_d;
    logic                    mismatch_q, mismatch_d;
    logic                    ff_valid_q, ff_valid_d;
    logic [2:0]              ff_sel_q, ff_sel_d;
    logic [4:0]              ff_exp_q, ff_exp_d;
    logic [4:0]              ff_got_q, ff_got_d;

    logic                    start_ok;
    logic                    accept;
    logic                    tail_vld;
    logic [4:0]              tail_exp;
    logic [2:0]              tail_sel;
    logic [4:0]              got;

    assign tail_vld = pipe_vld_q[LATENCY-1];
    assign tail_exp = pipe_exp_q[LATENCY-1];
    assign tail_sel = pipe_sel_q[LATENCY-1];
    assign got      = {dut_cout, dut_out};

    // Acceptance, expected-result pipe and run FSM.
    always_comb begin
        state_d     = state_q;
        accepted_d  = accepted_q;
        vec_total_d = vec_total_q;
        start_ok    = 1'b0;
        accept      = 1'b0;
        pipe_vld_d  = '0;
        pipe_exp_d  = '0;
        pipe_sel_d  = '0;

        if (state_q == ST_RUN) begin
            accept = in_valid;
        end
        if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
            start_ok = 1'b1;
        end

        pipe_vld_d[0] = accept;
        pipe_exp_d[0] = golden(select, a, b, c_in);
        pipe_sel_d[0] = select;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_exp_d[i] = pipe_exp_q[i-1];
            pipe_sel_d[i] = pipe_sel_q[i-1];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    accepted_d  = '0;
                    vec_total_d = vec_total;
                    // An empty run completes immediately without passing through RUN.
                    state_d     = (vec_total == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    accepted_d = accepted_q + CNT_ONE;
                    if (accepted_d == vec_total_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that retires the last entry so done and the
                // final counts become visible together.
                if (pipe_vld_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Compare at the pipe tail, statistics and first-failure capture.
    always_comb begin
        pass_d     = pass_q;
        fail_d     = fail_q;
        mismatch_d = 1'b0;
        ff_valid_d = ff_valid_q;
        ff_sel_d   = ff_sel_q;
        ff_exp_d   = ff_exp_q;
        ff_got_d   = ff_got_q;

        if (start_ok) begin
            pass_d     = '0;
            fail_d     = '0;
            ff_valid_d = 1'b0;
            ff_sel_d   = '0;
            ff_exp_d   = '0;
            ff_got_d   = '0;
        end else if (tail_vld) begin
            if (got == tail_exp) begin
                if (pass_q != CNT_MAX) begin
                    pass_d = pass_q + CNT_ONE;
                end
            end else begin
                mismatch_d = 1'b1;
                if (fail_q != CNT_MAX) begin
                    fail_d = fail_q + CNT_ONE;
                end
                if (!ff_valid_q) begin
                    ff_valid_d = 1'b1;
                    ff_sel_d   = tail_sel;
                    ff_exp_d   = tail_exp;
                    ff_got_d   = got;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            accepted_q  <= '0;
            vec_total_q <= '0;
            pipe_vld_q  <= '0;
            pipe_exp_q  <= '0;
            pipe_sel_q  <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            mismatch_q  <= 1'b0;
            ff_valid_q  <= 1'b0;
            ff_sel_q    <= '0;
            ff_exp_q    <= '0;
            ff_got_q    <= '0;
        end else begin
            state_q     <= state_d;
            accepted_q  <= accepted_d;
            vec_total_q <= vec_total_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_exp_q  <= pipe_exp_d;
            pipe_sel_q  <= pipe_sel_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            mismatch_q  <= mismatch_d;
            ff_valid_q  <= ff_valid_d;
            ff_sel_q    <= ff_sel_d;
            ff_exp_q    <= ff_exp_d;
            ff_got_q    <= ff_got_d;
        end
    end

    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign mismatch   = mismatch_q;
    assign pass_count = pass_q;
    assign fail_count = fail_q;
    assign ff_valid   = ff_valid_q;
    assign ff_sel     = ff_sel_q;
    assign ff_exp     = ff_exp_q;
    assign ff_got     = ff_got_q;

endmodule
